pixel_packer_8pix: RTL and testbench
====================================

// Module: pixel_packer_8pix
// PURPOSE
//  Front end of the row-buffer chain for the convolution kernel. Packs a 1-pixel/clk
//  raster stream into PIXCNT-pixel words and drives D/enable of the 8-pixel line buffers.
//  Tracks columns per line, pads partial last words, and flags malformed lines.
//  Output words are the producer-side format consumed by the line buffers (pixel 0 in LSBs).
// PARAMETERS
//  DWIDTH  10          bits per pixel
//  PIXCNT  8           pixels per packed word
//  COLS    2448        max columns per line
//  DEPTH   COLS/PIXCNT max words per line
//  PAD_VAL 0           value for unused lanes of a partial last word
// PORTS
//  clk        in   1                Clock. Single clock domain.
//  rst        in   1                Reset. Synchronous, active-high.
//  cols_N     in   $clog2(COLS+1)   Active columns per line. Sampled on in_sol. Range 1..COLS.
//  in_data    in   DWIDTH           Pixel.
//  in_valid   in   1                Pixel qualifier. Gaps are allowed; there is no backpressure.
//  in_sol     in   1                First pixel of line (qualified by in_valid).
//  in_eol     in   1                Last pixel of line (qualified by in_valid).
//  word_out   out  DWIDTH*PIXCNT    Packed word. Lane k = bits [k*DWIDTH +: DWIDTH].
//  word_valid out  1                Word strobe. Drives the line buffer enable.
//  word_sol   out  1                First word of line.
//  word_eol   out  1                Last word of line.
//  word_idx   out  $clog2(DEPTH)    Word index within the line. 0 at sol.
//  err_short  out  1                1-cycle pulse: line ended before cols_N pixels.
//  err_long   out  1                1-cycle pulse: pixel count hit cols_N with no in_eol.
// BEHAVIOUR
//  - Reset: every output is 0. FSM goes to IDLE. Lane count, column count and accumulator clear.
//  - FSM has three states:
//    - IDLE: in_valid without in_sol is dropped. in_valid & in_sol -> PACK.
//    - PACK: accumulate pixels into lanes 0..PIXCNT-1.
//    - DISCARD: drop pixels until in_valid & in_sol; that pixel starts a new line (-> PACK).
//  - Word emission:
//    - When lane PIXCNT-1 fills, or a line terminates, the word is registered.
//    - word_valid is high for exactly 1 cycle; latency is 1 clk after the last pixel's in_valid.
//    - Unfilled lanes = PAD_VAL.
//  - Line termination:
//    - Normal end: in_eol with colcnt+1 == cols_N -> word_eol=1, -> IDLE.
//    - in_eol early (colcnt+1 < cols_N): flush the partial word with word_eol=1,
//      pulse err_short, -> IDLE.
//    - colcnt+1 == cols_N without in_eol: flush with word_eol=1, pulse err_long, -> DISCARD.
//    - in_sol while in PACK (mid-line): flush the accumulated partial word with word_eol=1
//      and pulse err_short. In the same cycle the new pixel loads lane 0 and a new line starts.
//      This old-word emit and new-pixel capture must not lose a pixel.
//    - in_sol & in_eol together with cols_N==1: one word {PAD..., pix}, with sol=eol=1.
//  - word_sol=1 on the first word emitted after the sol pixel. word_idx increments per word
//    and wraps to 0 at each line.
//  - cols_N is sampled only on in_sol. A mid-line change has no effect.
//  - rst mid-line: the partial word is discarded with no emission. The next word needs a fresh sol.
//  - Pixels are never reordered. Lane k holds column (word_idx*PIXCNT + k).
// CONFIGURATION
//  - PACK_EDGE_REPLICATE_EN:
//    - Defined: unfilled lanes of a partial word take the last valid pixel of the line
//      (border replication for the kernel).
//    - Undefined: unfilled lanes take PAD_VAL.
//  - Full-word behaviour is identical either way.
// STRUCTURE
//  - Package line_buf_pkg:
//    - localparams PIXCNT and DWIDTH defaults
//    - typedef pix_t [DWIDTH-1:0]
//    - typedef word_t [DWIDTH*PIXCNT-1:0]
//    - enum pack_state_t {IDLE, PACK, DISCARD}
//  - Sub-module lane_pad_mux: combinational fill of unfilled lanes from lane count
//    (PAD_VAL or replicate). Instantiated once at the output register input.
// TESTING
//  1. cols_N=16, 16 pixels 0..15, sol on px0, eol on px15 -> 2 words;
//     word0 lanes=0..7 sol=1 idx=0; word1 lanes=8..15 eol=1 idx=1.
//  2. cols_N=13, pixels 0..12 with eol on px12 -> word1 = {PAD,PAD,PAD,12,11,10,9,8}.
//     With PACK_EDGE_REPLICATE_EN the PAD lanes are 12,12,12.
//  3. cols_N=16, eol on px9 -> word1 lanes 8,9 then PAD, eol=1, err_short=1 for one cycle;
//     next sol line packs normally.
//  4. cols_N=8, 12 pixels, no eol -> one word 0..7 eol=1, err_long=1; px8..11 dropped;
//     next sol accepted.
//  5. sol on cycle 5 while lanes 0..2 are full -> partial word emitted with err_short,
//     and the sol pixel appears in lane 0 of the next word.
//  6. in_valid toggling 1/0, and rst asserted after 3 pixels -> outputs 0 next cycle,
//     no word emitted, no pixel lost or duplicated across the gaps.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared types for the row-buffer front end: default pixel/word geometry,
// pixel and packed-word types, and the packer FSM state encoding.
package line_buf_pkg;

    localparam int DWIDTH = 10;
    localparam int PIXCNT = 8;

    typedef logic [DWIDTH-1:0]        pix_t;
    typedef logic [DWIDTH*PIXCNT-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DISCARD
    } pack_state_t;

endpackage

// File: rtl/lane_pad_mux.sv
// Fills the unused lanes of a packed word. Lanes below 'fill' pass through;
// the rest take PAD_VAL, or the last valid pixel when the build defines
// PACK_EDGE_REPLICATE_EN (border replication for the convolution kernel).
module lane_pad_mux #(
    parameter int          DWIDTH  = 10,
    parameter int          PIXCNT  = 8,
    parameter int unsigned PAD_VAL = 0
) (
    input  logic [DWIDTH*PIXCNT-1:0]     word_in,
    input  logic [$clog2(PIXCNT+1)-1:0]  fill,
    output logic [DWIDTH*PIXCNT-1:0]     word_out
);

    localparam int NW = $clog2(PIXCNT + 1);

    logic [DWIDTH-1:0] fill_val;

    // Pick the filler value, then keep or replace each lane by its index.
    always_comb begin
        // NOTE: every variable gets a default at the top of a combinational block so no path leaves it unassigned and infers a latch.
        fill_val = DWIDTH'(PAD_VAL);
        word_out = '0;
`ifdef PACK_EDGE_REPLICATE_EN
        for (int k = 0; k < PIXCNT; k++) begin
            if (NW'(k + 1) == fill) begin
                fill_val = word_in[k*DWIDTH +: DWIDTH];
            end
        end
`else
`endif
        for (int k = 0; k < PIXCNT; k++) begin
            word_out[k*DWIDTH +: DWIDTH] = (NW'(k) < fill) ? word_in[k*DWIDTH +: DWIDTH] : fill_val;
        end
    end

endmodule

// File: rtl/pixel_packer_8pix.sv
// Packs a 1-pixel/clk raster stream into PIXCNT-pixel words for the line
// buffers (pixel 0 in the LSBs), tracks columns, pads partial last words and
// flags short/long lines. Optional build macro: PACK_EDGE_REPLICATE_EN
// (partial-word lanes replicate the last pixel instead of PAD_VAL).
// A mid-line sol whose new pixel also closes a word (cols_N==1) needs two
// words in one cycle; the second is held one cycle in a pending slot.
module pixel_packer_8pix #(
    parameter int          DWIDTH  = 10,
    parameter int          PIXCNT  = 8,
    parameter int          COLS    = 2448,
    parameter int          DEPTH   = COLS / PIXCNT,
    parameter int unsigned PAD_VAL = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(COLS+1)-1:0]   cols_N,
    input  logic [DWIDTH-1:0]           in_data,
    input  logic                        in_valid,
    input  logic                        in_sol,
    input  logic                        in_eol,
    output logic [DWIDTH*PIXCNT-1:0]    word_out,
    output logic                        word_valid,
    output logic                        word_sol,
    output logic                        word_eol,
    output logic [$clog2(DEPTH)-1:0]    word_idx,
    output logic                        err_short,
    output logic                        err_long
);

    import line_buf_pkg::*;

    localparam int CW = $clog2(COLS + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int NW = $clog2(PIXCNT + 1);
    localparam int WW = DWIDTH * PIXCNT;

    pack_state_t state_q, state_d;

    logic [WW-1:0] acc_q;
    logic [NW-1:0] lane_q;
    logic [CW-1:0] col_q, lim_q;
    logic [IW-1:0] idx_q;
    logic          first_q;

    logic          pend_vld_q, pend_sol_q, pend_eol_q;
    logic [WW-1:0] pend_word_q;
    logic [NW-1:0] pend_fill_q;
    logic [IW-1:0] pend_idx_q;

    logic          start, take, restart, flush_old;
    logic [WW-1:0] base_acc, ins_acc;
    logic [NW-1:0] base_lane;
    logic [CW-1:0] base_col, base_lim, col_next;
    logic [IW-1:0] base_idx;
    logic          base_first, full, hit_lim, term, new_emit;
    logic          short_new, long_new, pend_load;
    logic          out_vld, sel_sol, sel_eol;
    logic [WW-1:0] sel_word, padded;
    logic [NW-1:0] sel_fill;
    logic [IW-1:0] sel_idx;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: an accepted pixel either keeps the line open or ends it.
    always_comb begin
        state_d = state_q;
        if (take) begin
            if (!term)       state_d = PACK;
            else if (in_eol) state_d = IDLE;
            else             state_d = DISCARD;
        end
    end

    // Datapath decode: lane insertion, termination and word source selection.
    always_comb begin
        start      = in_valid & in_sol;
        take       = in_valid & (in_sol | (state_q == PACK));
        restart    = start & (state_q == PACK);
        flush_old  = restart & (lane_q != '0);

        base_acc   = start ? '0        : acc_q;
        base_lane  = start ? '0        : lane_q;
        base_col   = start ? '0        : col_q;
        base_lim   = start ? cols_N    : lim_q;
        base_idx   = start ? '0        : idx_q;
        base_first = start ? 1'b1      : first_q;

        ins_acc = base_acc;
        for (int k = 0; k < PIXCNT; k++) begin
            if (base_lane == NW'(k)) ins_acc[k*DWIDTH +: DWIDTH] = in_data;
        end

        col_next  = base_col + 1'b1;
        full      = (base_lane == NW'(PIXCNT - 1));
        hit_lim   = (col_next == base_lim);
        term      = in_eol | hit_lim;
        new_emit  = take & (full | term);
        short_new = take & in_eol & (col_next < base_lim);
        long_new  = take & ~in_eol & hit_lim;
        pend_load = new_emit & (pend_vld_q | flush_old);

        out_vld  = 1'b0;
        sel_word = ins_acc;
        sel_fill = base_lane + 1'b1;
        sel_sol  = base_first;
        sel_eol  = term;
        sel_idx  = base_idx;
        if (pend_vld_q) begin
            out_vld  = 1'b1;
            sel_word = pend_word_q;
            sel_fill = pend_fill_q;
            sel_sol  = pend_sol_q;
            sel_eol  = pend_eol_q;
            sel_idx  = pend_idx_q;
        end else if (flush_old) begin
            out_vld  = 1'b1;
            sel_word = acc_q;
            sel_fill = lane_q;
            sel_sol  = first_q;
            sel_eol  = 1'b1;
            sel_idx  = idx_q;
        end else if (new_emit) begin
            out_vld  = 1'b1;
        end
    end

    lane_pad_mux #(
        .DWIDTH  (DWIDTH),
        .PIXCNT  (PIXCNT),
        .PAD_VAL (PAD_VAL)
    ) u_pad (
        .word_in  (sel_word),
        .fill     (sel_fill),
        .word_out (padded)
    );

    // Accumulator, line counters, pending slot and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            lane_q      <= '0;
            col_q       <= '0;
            lim_q       <= '0;
            idx_q       <= '0;
            first_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_word_q <= '0;
            pend_fill_q <= '0;
            pend_sol_q  <= 1'b0;
            pend_eol_q  <= 1'b0;
            pend_idx_q  <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            word_sol    <= 1'b0;
            word_eol    <= 1'b0;
            word_idx    <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
        end else begin
            if (take) begin
                col_q <= col_next;
                lim_q <= base_lim;
                if (new_emit) begin
                    acc_q   <= '0;
                    lane_q  <= '0;
                    idx_q   <= base_idx + 1'b1;
                    first_q <= 1'b0;
                end else begin
                    acc_q   <= ins_acc;
                    lane_q  <= base_lane + 1'b1;
                    idx_q   <= base_idx;
                    first_q <= base_first;
                end
            end

            if (pend_load) begin
                pend_vld_q  <= 1'b1;
                pend_word_q <= ins_acc;
                pend_fill_q <= base_lane + 1'b1;
                pend_sol_q  <= base_first;
                pend_eol_q  <= term;
                pend_idx_q  <= base_idx;
            end else if (pend_vld_q) begin
                pend_vld_q  <= 1'b0;
            end

            word_valid <= out_vld;
            word_out   <= out_vld ? padded  : '0;
            word_sol   <= out_vld & sel_sol;
            word_eol   <= out_vld & sel_eol;
            word_idx   <= out_vld ? sel_idx : '0;
            err_short  <= restart | short_new;
            err_long   <= long_new;
        end
    end

endmodule

// File: tb/tb_pixel_packer_8pix.sv
// Self-checking bench for pixel_packer_8pix: table of stimulus records with
// expected words pushed to a scoreboard when driven; a negedge monitor pops
// and compares. Build with +define+PACK_EDGE_REPLICATE_EN to expect
// replicated border lanes.
module tb_pixel_packer_8pix;
    import line_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cols_N;
    pix_t        in_data;
    logic        in_valid, in_sol, in_eol;
    word_t       word_out;
    logic        word_valid, word_sol, word_eol;
    logic [8:0]  word_idx;
    logic        err_short, err_long;

    pixel_packer_8pix dut (
        .clk        (clk),
        .rst        (rst),
        .cols_N     (cols_N),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sol     (in_sol),
        .in_eol     (in_eol),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_sol   (word_sol),
        .word_eol   (word_eol),
        .word_idx   (word_idx),
        .err_short  (err_short),
        .err_long   (err_long)
    );

    always #5 clk = ~clk;

    typedef struct {
        pix_t        d;
        logic        v, sol, eol, rst;
        logic [11:0] cols;
        logic        emit;
        word_t       w;
        logic        esol, eeol;
        logic [8:0]  idx;
        logic        es, el;
    } vec_t;

    typedef struct {
        word_t      w;
        logic       sol, eol;
        logic [8:0] idx;
        logic       es, el;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Expected word: lanes 0..n-1 hold base+k, remaining lanes are filler.
    function automatic word_t mk(input int base, input int n);
        word_t w;
        pix_t  fill;
`ifdef PACK_EDGE_REPLICATE_EN
        fill = pix_t'(base + n - 1);
`else
        fill = '0;
`endif
        for (int k = 0; k < 8; k++) w[k*10 +: 10] = (k < n) ? pix_t'(base + k) : fill;
        return w;
    endfunction

    function automatic vec_t V(input int d, input bit v, input bit sol, input bit eol, input int cols);
        vec_t x;
        x.d = pix_t'(d); x.v = v; x.sol = sol; x.eol = eol; x.rst = 1'b0;
        x.cols = 12'(cols); x.emit = 1'b0; x.w = '0; x.esol = 1'b0; x.eeol = 1'b0;
        x.idx = '0; x.es = 1'b0; x.el = 1'b0;
        return x;
    endfunction

    function automatic vec_t E(input int d, input bit sol, input bit eol, input int cols, input word_t w,
                               input bit esol, input bit eeol, input int idx, input bit es, input bit el);
        vec_t x;
        x = V(d, 1'b1, sol, eol, cols);
        x.emit = 1'b1; x.w = w; x.esol = esol; x.eeol = eeol; x.idx = 9'(idx); x.es = es; x.el = el;
        return x;
    endfunction

    task automatic apply(input vec_t x);
        exp_t e;
        rst = x.rst; in_data = x.d; in_valid = x.v; in_sol = x.sol; in_eol = x.eol; cols_N = x.cols;
        if (x.emit) begin
            e.w = x.w; e.sol = x.esol; e.eol = x.eeol; e.idx = x.idx; e.es = x.es; e.el = x.el;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: compare each emitted word, and require quiet outputs otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (word_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {word_out, word_idx}, '0);
                end else begin
                    mon_e = sb.pop_front();
                    check("word_out",  word_out,  mon_e.w);
                    check("word_sol",  word_sol,  mon_e.sol);
                    check("word_eol",  word_eol,  mon_e.eol);
                    check("word_idx",  word_idx,  mon_e.idx);
                    check("err_short", err_short, mon_e.es);
                    check("err_long",  err_long,  mon_e.el);
                end
            end else begin
                check("idle_outputs", {word_out, word_sol, word_eol, word_idx, err_short, err_long}, '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Line of 16: two full words, mid-line cols_N change ignored.
        for (int i = 0; i < 16; i++) begin
            if (i == 7)       tbl.push_back(E(i, 0, 0, 16, mk(0, 8), 1, 0, 0, 0, 0));
            else if (i == 15) tbl.push_back(E(i, 0, 1, 5,  mk(8, 8), 0, 1, 1, 0, 0));
            else              tbl.push_back(V(i, 1, i == 0, 0, (i < 10) ? 16 : 5));
        end
        // Stray pixel without sol while idle is dropped.
        tbl.push_back(V(500, 1, 0, 0, 16));
        // Line of 13 with gaps: partial last word padded.
        for (int i = 0; i < 13; i++) begin
            if (i == 7)       tbl.push_back(E(i, 0, 0, 13, mk(0, 8), 1, 0, 0, 0, 0));
            else if (i == 12) tbl.push_back(E(i, 0, 1, 13, mk(8, 5), 0, 1, 1, 0, 0));
            else              tbl.push_back(V(i, 1, i == 0, 0, 13));
            if (i == 3 || i == 9) tbl.push_back(V(0, 0, 0, 0, 13));
        end
        // Early eol on px9 of a 16 line, then a normal 8-pixel line.
        for (int i = 0; i < 10; i++) begin
            if (i == 7)      tbl.push_back(E(i, 0, 0, 16, mk(0, 8), 1, 0, 0, 0, 0));
            else if (i == 9) tbl.push_back(E(i, 0, 1, 16, mk(8, 2), 0, 1, 1, 1, 0));
            else             tbl.push_back(V(i, 1, i == 0, 0, 16));
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) tbl.push_back(E(57, 0, 1, 8, mk(50, 8), 1, 1, 0, 0, 0));
            else        tbl.push_back(V(50 + i, 1, i == 0, 0, 8));
        end
        // Long line: 12 pixels with cols_N=8 and no eol; px8..11 dropped.
        for (int i = 0; i < 12; i++) begin
            if (i == 7) tbl.push_back(E(i, 0, 0, 8, mk(0, 8), 1, 1, 0, 0, 1));
            else        tbl.push_back(V(i, 1, i == 0, 0, 8));
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) tbl.push_back(E(72, 0, 1, 3, mk(70, 3), 1, 1, 0, 0, 0));
            else        tbl.push_back(V(70 + i, 1, i == 0, 0, 3));
        end
        // Single-pixel line: sol and eol together with cols_N=1.
        tbl.push_back(E(99, 1, 1, 1, mk(99, 1), 1, 1, 0, 0, 0));

        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0; cols_N = 12'd16;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {word_out, word_valid, word_sol, word_eol, word_idx, err_short, err_long}, '0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Mid-line sol after three pixels: flush {0,1,2}, new line starts at 40.
        apply(V(0, 1, 1, 0, 16));
        apply(V(1, 1, 0, 0, 16));
        apply(V(2, 1, 0, 0, 16));
        apply(V(0, 0, 0, 0, 16));
        apply(E(40, 1, 0, 8, mk(0, 3), 1, 1, 0, 1, 0));
        for (int i = 1; i < 7; i++) apply(V(40 + i, 1, 0, 0, 8));
        apply(E(47, 0, 1, 8, mk(40, 8), 1, 1, 0, 0, 0));

        // Toggling valid, then reset after three pixels: nothing emitted.
        apply(V(0, 1, 1, 0, 8));
        apply(V(0, 0, 0, 0, 8));
        apply(V(1, 1, 0, 0, 8));
        apply(V(0, 0, 0, 0, 8));
        apply(V(2, 1, 0, 0, 8));
        apply(V(0, 0, 0, 0, 8));
        begin
            vec_t r;
            r = V(3, 1, 0, 0, 8);
            r.rst = 1'b1;
            apply(r);
        end
        check("rst_midline_outputs", {word_out, word_valid, word_sol, word_eol, word_idx, err_short, err_long}, '0);
        apply(V(4, 1, 0, 0, 8));
        for (int i = 0; i < 8; i++) begin
            if (i == 7) apply(E(17, 0, 1, 8, mk(10, 8), 1, 1, 0, 0, 0));
            else        apply(V(10 + i, 1, i == 0, 0, 8));
            if (i < 7)  apply(V(0, 0, 0, 0, 8));
        end

        repeat (4) apply(V(0, 0, 0, 0, 8));
        check("scoreboard_drained", 128'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
